// File: rtl/wb_commit_unit.sv
// -----------------------------------------------------------------------------
// wb_commit_unit
//
// Writeback/commit end of the MEM/WB pipeline register of the pipelined MIPS
// CPU. It selects the register-file write data, owns the architectural HI/LO
// registers and the CP0 Status/Cause/EPC/Count registers, and turns a
// syscall/eret into a one-cycle PC redirect. The instruction that sits in WB
// during that redirect cycle is on the wrong path and is not committed.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   MemtoReg, RegWr     load-data select, register write request
//   Dout                memory read word
//   Result              ALU result / mthi-mtlo-mtc0 data / LB(U) byte address
//   PC                  PC of the instruction in WB
//   rw                  destination register
//   link .. eret        instruction class flags (at most one set)
//   mult_Result         {hi,lo} product
//   cpnum               CP0 register number
//   reg_we/waddr/wdata  register-file write port
//   hi, lo              architectural HI/LO
//   status, cause, epc  CP0 registers
//   redirect_valid/pc   one-cycle redirect to fetch/flush logic
// -----------------------------------------------------------------------------
module wb_commit_unit #(
   parameter logic [31:0] EXC_VECTOR  = 32'h0000_4180,
   parameter logic [31:0] LINK_OFFSET = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemtoReg,
   input  logic        RegWr,
   input  logic [31:0] Dout,
   input  logic [31:0] Result,
   input  logic [31:0] PC,
   input  logic [4:0]  rw,
   input  logic        link,
   input  logic        LB,
   input  logic        LBU,
   input  logic        mult,
   input  logic        mfhi,
   input  logic        mflo,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic        mfc0,
   input  logic        mtc0,
   input  logic        syscall,
   input  logic        eret,
   input  logic [63:0] mult_Result,
   input  logic [4:0]  cpnum,
   output logic        reg_we,
   output logic [4:0]  reg_waddr,
   output logic [31:0] reg_wdata,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] status,
   output logic [31:0] cause,
   output logic [31:0] epc,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   localparam int unsigned DATA_W = 32;

   localparam logic [4:0] CP0_COUNT  = 5'd9;
   localparam logic [4:0] CP0_STATUS = 5'd12;
   localparam logic [4:0] CP0_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_EPC    = 5'd14;

   typedef enum logic {
      ST_NORMAL   = 1'b0,
      ST_REDIRECT = 1'b1
   } state_t;

   state_t              state_p1, state_d;
   logic [DATA_W-1:0]   count_p1;
   logic                commit;
   logic                except;

   // Little-endian byte select from a loaded word, sign- or zero-extended.
   function automatic logic [DATA_W-1:0] load_byte(input logic [DATA_W-1:0] word,
                                                    input logic [1:0]        sel,
                                                    input logic              sext);
      logic signed [7:0]        b;
      logic signed [DATA_W-1:0] b_ext;
      b     = word[8*sel +: 8];
      b_ext = b;
      return sext ? b_ext : {24'd0, b};
   endfunction

   function automatic logic [DATA_W-1:0] cp0_read(input logic [4:0]        num,
                                                   input logic [DATA_W-1:0] st,
                                                   input logic [DATA_W-1:0] ca,
                                                   input logic [DATA_W-1:0] ep,
                                                   input logic [DATA_W-1:0] cnt);
      case (num)
         CP0_STATUS: return st;
         CP0_CAUSE:  return ca;
         CP0_EPC:    return ep;
         CP0_COUNT:  return cnt;
         default:    return '0;
      endcase
   endfunction

   assign commit = (state_p1 == ST_NORMAL);
   assign except = syscall | eret;

   // Next-state and redirect pulse
   always_comb begin
      state_d        = state_p1;
      redirect_valid = 1'b0;
      case (state_p1)
         ST_NORMAL: begin
            if (except) state_d = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            redirect_valid = 1'b1;
            state_d        = ST_NORMAL;
         end
         default: state_d = ST_NORMAL;
      endcase
   end

   // Register-file write port: combinational from the current WB bundle
   always_comb begin
      reg_waddr = rw;
      reg_we    = RegWr & (rw != 5'd0) & commit & ~except;
      if (link)
         reg_wdata = PC + LINK_OFFSET;
      else if (mfhi)
         reg_wdata = hi;
      else if (mflo)
         reg_wdata = lo;
      else if (mfc0)
         reg_wdata = cp0_read(cpnum, status, cause, epc, count_p1);
      else if (MemtoReg && (LB || LBU))
         reg_wdata = load_byte(Dout, Result[1:0], LB);
      else if (MemtoReg)
         reg_wdata = Dout;
      else
         reg_wdata = Result;
   end

   // Architectural state update at the commit edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_p1    <= ST_NORMAL;
         hi          <= '0;
         lo          <= '0;
         status      <= '0;
         cause       <= '0;
         epc         <= '0;
         count_p1    <= '0;
         redirect_pc <= '0;
      end else begin
         state_p1 <= state_d;
         // Free-running; an mtc0 to Count below overrides this increment.
         count_p1 <= count_p1 + 32'd1;
         if (commit) begin
            if (syscall) begin
               // Nested syscall keeps the original return address.
               if (!status[1]) epc <= PC;
               cause[6:2]  <= 5'd8;
               status[1]   <= 1'b1;
               redirect_pc <= EXC_VECTOR;
            end else if (eret) begin
               status[1]   <= 1'b0;
               redirect_pc <= epc;
            end else if (mtc0) begin
               case (cpnum)
                  CP0_STATUS: status   <= Result;
                  CP0_EPC:    epc      <= Result;
                  CP0_COUNT:  count_p1 <= Result;
                  default: ;
               endcase
            end else if (mult) begin
               {hi, lo} <= mult_Result;
            end else begin
               if (mthi) hi <= Result;
               if (mtlo) lo <= Result;
            end
         end
      end
   end

endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
- Writeback and commit end of the MEM/WB pipeline register in the pipelined MIPS CPU.
- Consumes the registered MEM/WB fields and produces the register-file write port.
- Owns the architectural HI/LO registers and the CP0 Status, Cause, EPC and Count registers.
- Resolves syscall/eret into a registered PC redirect. While that redirect is pending, it suppresses commit of the one wrong-path instruction behind it.

Parameters:
- EXC_VECTOR, 32'h0000_4180, PC loaded on syscall redirect.
- LINK_OFFSET, 4, added to PC for link writes (no delay slot).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous reset, active-low.
- MemtoReg  in  1  select load data.
- RegWr  in  1  register write request.
- Dout  in  32  memory read word.
- Result  in  32  ALU result; also the data source for mthi/mtlo/mtc0, and the byte address for LB/LBU.
- PC  in  32  PC of the instruction in WB.
- rw  in  5  destination register.
- link, LB, LBU, mult, mfhi, mflo, mthi, mtlo, mfc0, mtc0, syscall, eret  in  1 each  instruction class flags.
- mult_Result  in  64  {hi,lo} product.
- cpnum  in  5  CP0 register number.
- reg_we  out  1  register-file write enable.
- reg_waddr  out  5  write address.
- reg_wdata  out  32  write data.
- hi, lo  out  32 each  architectural HI/LO.
- status, cause, epc  out  32 each  CP0 registers.
- redirect_valid  out  1  one-cycle redirect pulse to fetch/flush logic.
- redirect_pc  out  32  redirect target.

Behaviour:
- Reset (rst_n=0 at posedge):
  - hi, lo, status, cause, epc, Count, redirect_pc = 0.
  - redirect_valid = 0; state = NORMAL.
  - Reset overrides everything, including a syscall or eret in the same cycle.
- An all-zero input bundle (bubble) is a NOP: no state change, reg_we = 0.
- State machine:
  - NORMAL: the instruction commits.
    - syscall or eret present → REDIRECT next cycle.
  - REDIRECT: lasts exactly one cycle; redirect_valid = 1.
    - The instruction in WB is discarded: reg_we = 0; no HI/LO or CP0 writes; a syscall/eret in WB is ignored.
    - Returns to NORMAL next cycle.
- Write data priority (combinational, from the current inputs):
  - link: PC + LINK_OFFSET.
  - mfhi: hi. mflo: lo.
  - mfc0: CP0 read of cpnum (12 Status, 13 Cause, 14 EPC, 9 Count, any other 0).
  - MemtoReg with LB: byte Dout[8*Result[1:0]+:8], sign-extended (little-endian).
  - MemtoReg with LBU: the same byte, zero-extended.
  - MemtoReg otherwise: Dout.
  - else: Result.
- reg_we = RegWr & (rw != 0) & state==NORMAL & !syscall & !eret.
- reg_waddr = rw. When link is set, the decoder supplies rw = 31.
- HI/LO (posedge, NORMAL only):
  - mult: {hi,lo} <= mult_Result.
  - mthi: hi <= Result. mtlo: lo <= Result.
  - mfhi/mflo read the pre-update value; prior instructions have already committed.
- CP0 writes (mtc0, NORMAL only):
  - cpnum 12 → status <= Result. cpnum 14 → epc <= Result. cpnum 9 → Count <= Result.
  - cpnum 13 (cause) and any other cpnum: write ignored.
- Count:
  - Increments by 1 every cycle not in reset, wrapping 0xFFFFFFFF→0.
  - An mtc0 load of Count takes precedence over the increment.
- syscall (NORMAL):
  - If status[1]==0, epc <= PC. If status[1]==1, epc is unchanged.
  - cause[6:2] <= 5'd8; status[1] <= 1.
  - Next cycle: redirect_valid = 1, redirect_pc = EXC_VECTOR.
- eret (NORMAL):
  - status[1] <= 0.
  - Next cycle: redirect_valid = 1, redirect_pc = epc value at the eret cycle.
- More than one flag set is illegal. Priority is syscall > eret > mtc0 > mult/mthi/mtlo.
- Latency:
  - Register writes are visible to the register file in the same cycle.
  - HI/LO/CP0 outputs change at the next edge.
  - Redirect follows one edge after the syscall/eret.

Test Plan:
1. Reset: hold rst_n=0 with syscall=1 → after the edge, all outputs 0, redirect_valid=0, state NORMAL.
2. Load byte: MemtoReg=1, LB=1, Dout=32'h80FF_1234, Result[1:0]=3, rw=5, RegWr=1 → reg_wdata=32'hFFFF_FF80, reg_we=1.
   - Same inputs with LBU=1 instead of LB → reg_wdata=32'h0000_0080.
3. HI/LO:
   - mult with mult_Result=64'h1_0000_0002 → hi=1, lo=2 next cycle.
   - Following mfhi, rw=8 → reg_wdata=1.
   - mthi with Result=7 → hi=7.
4. Syscall:
   - status=0, PC=0x40 → next cycle epc=0x40, cause[6:2]=8, status[1]=1, redirect_valid=1, redirect_pc=0x4180.
   - The RegWr=1 instruction in that cycle → reg_we=0, and the cycle after reg_we resumes.
5. Nested syscall and eret:
   - Second syscall with status[1]=1, PC=0x80 → epc stays 0x40.
   - eret → status[1]=0, redirect_pc=0x40.
6. Count and CP0 writes:
   - mtc0 cpnum=9, Result=32'hFFFF_FFFF → Count=FFFF_FFFF, then 0 the following cycle.
   - mtc0 cpnum=13 → cause unchanged.
   - rw=0 with RegWr=1 → reg_we=0.
